// File: rtl/harris_pkg.sv
// Shared definitions for the Harris corner pipeline.
//   frame_state_t : frame sequencer states
//   PIX_W         : pixel width
//   IMG_W_DEF / IMG_H_DEF / WIN_DEF : default geometry, shared with harrisDetector
package harris_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;
  localparam int WIN_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } frame_state_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : return to (0,0)
//   inc        : advance one pixel (column first, then row)
//   col, row   : current position
//   last       : position is (IMG_W-1, IMG_H-1)
module pixel_pos_counter #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/harris_frame_ctrl.sv
// Frame sequencer in front of harrisDetector. Takes one raw frame per start
// command under valid/ready, forwards it with raster coordinates and frame/line
// markers (1-cycle registered latency), then emits FLUSH_LEN zero pixels to
// drain the detector line buffers and pulses done.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a frame (honoured in IDLE only)
//   pixel / pixel_valid / pixel_ready : upstream handshake
//   det_pixel, det_valid, det_sof, det_eol, det_flush, win_valid, col, row
//                         : registered stream to the detector
//   busy                  : sequencer not idle
//   done                  : one-cycle end-of-frame pulse
//   frame_cnt             : frames completed (wraps)
module harris_frame_ctrl
  import harris_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int WIN       = WIN_DEF,
  parameter int FLUSH_LEN = 136,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] pixel,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic [PIX_W-1:0] det_pixel,
  output logic             det_valid,
  output logic             det_sof,
  output logic             det_eol,
  output logic             det_flush,
  output logic             win_valid,
  output logic [CW-1:0]    col,
  output logic [RW-1:0]    row,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt
);

  localparam int FW = $clog2(FLUSH_LEN + 1);

  frame_state_t  state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic          pos_last;
  logic          accept;
  logic          flush_last;

  // Ready decodes the state register only, so it never depends on pixel_valid.
  assign pixel_ready = (state == RUN);
  assign busy        = (state != IDLE);
  assign accept      = pixel_ready && pixel_valid;
  assign flush_last  = (flush_cnt == FW'(FLUSH_LEN - 1));

  pixel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .clear ((state == IDLE) && start),
    .inc   (accept),
    .col   (pos_col),
    .row   (pos_row),
    .last  (pos_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && pos_last) state_nxt = FLUSH;
      FLUSH:   if (flush_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts drain cycles already issued; parked at 0 outside FLUSH.
  always_ff @(posedge clk) begin
    if (reset || (state != FLUSH)) flush_cnt <= '0;
    else                           flush_cnt <= flush_cnt + 1'b1;
  end

  // Detector stream register. The first drain beat is issued on the edge right
  // after the last pixel is registered, so det_valid has no gap at the seam.
  // done is registered off the DONE state, landing in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      det_pixel <= '0;
      det_valid <= 1'b0;
      det_sof   <= 1'b0;
      det_eol   <= 1'b0;
      det_flush <= 1'b0;
      win_valid <= 1'b0;
      col       <= '0;
      row       <= '0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      det_valid <= 1'b0;
      det_sof   <= 1'b0;
      det_eol   <= 1'b0;
      det_flush <= 1'b0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      if (accept) begin
        det_pixel <= pixel;
        det_valid <= 1'b1;
        det_sof   <= (pos_col == '0) && (pos_row == '0);
        det_eol   <= (pos_col == CW'(IMG_W - 1));
        win_valid <= (pos_col >= CW'(WIN - 1)) && (pos_row >= RW'(WIN - 1));
        col       <= pos_col;
        row       <= pos_row;
      end else if (state == FLUSH) begin
        det_pixel <= '0;
        det_valid <= 1'b1;
        det_flush <= 1'b1;
      end
      if (state == DONE) begin
        done      <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
